// File: rtl/data_mem_sys.sv
// Data memory system: 64x32 word RAM plus MMIO block (output FIFO, status, cycle counter).
// Optional cycle counter is enabled by defining CYCLE_COUNTER_EN.
module data_mem_sys (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] alu_out,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        MMIO_FIFO    = 2'd0,
        MMIO_STATUS  = 2'd1,
        MMIO_COUNTER = 2'd2,
        MMIO_RSVD    = 2'd3
    } mmio_sel_e;

    logic [31:0] ram_q [64];
    logic [31:0] fifo_q [4];

    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        ovf_q, ovf_d;

    logic [5:0]  ram_idx;
    logic        sel_mmio;
    mmio_sel_e   mmio_sel;
    logic        full, empty;
    logic        push_req, push_ok, pop;
    logic        status_wr;
    logic [31:0] status_word;
    logic [31:0] counter_rd;

    // Address bits outside the decoded fields are deliberately ignored (aliasing).
    logic unused_addr;
    assign unused_addr = ^{alu_out[30:8], alu_out[1:0]};

    assign ram_idx  = alu_out[7:2];
    assign sel_mmio = alu_out[31];
    assign mmio_sel = mmio_sel_e'(alu_out[3:2]);

    assign empty       = (count_q == 3'd0);
    assign full        = (count_q == 3'd4);
    assign status_word = {26'b0, ovf_q, full, empty, count_q};

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : fifo_q[rd_ptr_q];

    assign push_req  = !reset && mem_write && sel_mmio && (mmio_sel == MMIO_FIFO);
    assign status_wr = !reset && mem_write && sel_mmio && (mmio_sel == MMIO_STATUS);
    assign pop       = !reset && out_valid && out_ready;
    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign push_ok   = push_req && (!full || pop);

`ifdef CYCLE_COUNTER_EN
    logic [31:0] cnt_q, cnt_d;
    logic        cnt_wr;

    assign cnt_wr = mem_write && sel_mmio && (mmio_sel == MMIO_COUNTER);

    always_comb begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_wr) begin
            cnt_d = write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign counter_rd = cnt_q;
`else
    assign counter_rd = '0;
`endif

    always_comb begin
        read_data = '0;
        if (!sel_mmio) begin
            read_data = ram_q[ram_idx];
        end else begin
            case (mmio_sel)
                MMIO_STATUS:  read_data = status_word;
                MMIO_COUNTER: read_data = counter_rd;
                default:      read_data = '0;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {2'b0, push_ok} - {2'b0, pop};
        ovf_d    = ovf_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        // A dropped push outranks a simultaneous status clear.
        if (push_req && full && !pop) begin
            ovf_d = 1'b1;
        end else if (status_wr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_write && !sel_mmio) begin
            ram_q[ram_idx] <= write_data;
        end
    end

endmodule

// File: tb/tb_data_mem_sys.sv
// Directed self-checking bench for data_mem_sys; expectations track CYCLE_COUNTER_EN.
module tb_data_mem_sys;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write;
    logic [31:0] alu_out;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    localparam logic [31:0] A_FIFO   = 32'h8000_0000;
    localparam logic [31:0] A_STATUS = 32'h8000_0004;
    localparam logic [31:0] A_CNT    = 32'h8000_0008;
    localparam logic [31:0] A_RSVD   = 32'h8000_000C;

    data_mem_sys dut (
        .clk        (clk),
        .reset      (reset),
        .mem_write  (mem_write),
        .alu_out    (alu_out),
        .write_data (write_data),
        .read_data  (read_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one cycle of inputs at the falling edge; outputs settle 1 time unit later.
    task automatic drive(input logic rst, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic rdy);
        @(negedge clk);
        reset      = rst;
        mem_write  = we;
        alu_out    = a;
        write_data = d;
        out_ready  = rdy;
        #1;
    endtask

    initial begin
        logic [31:0] pop_exp [4];
        pop_exp[0] = 32'h2;
        pop_exp[1] = 32'h3;
        pop_exp[2] = 32'h4;
        pop_exp[3] = 32'hA;

        reset = 1'b1; mem_write = 1'b0; alu_out = '0; write_data = '0; out_ready = 1'b0;
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        drive(0, 0, A_STATUS, 0, 0);
        check("rst_status", read_data, 32'h08);
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_odata", out_data, 32'h0);

        // RAM store, aliasing, byte-offset ignore
        drive(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        drive(0, 0, 32'h0000_0010, 0, 0);
        check("ram_rd", read_data, 32'hDEAD_BEEF);
        drive(0, 0, 32'h0000_0110, 0, 0);
        check("ram_alias", read_data, 32'hDEAD_BEEF);
        drive(0, 0, 32'h0000_0012, 0, 0);
        check("ram_byteoff", read_data, 32'hDEAD_BEEF);
        drive(0, 0, 32'h4000_0010, 0, 0);
        check("ram_alias_hi", read_data, 32'hDEAD_BEEF);

        // Read during write returns old data
        drive(0, 1, 32'h0000_0020, 32'h1111_1111, 0);
        drive(0, 1, 32'h0000_0020, 32'h2222_2222, 0);
        check("ram_rdw_old", read_data, 32'h1111_1111);
        drive(0, 0, 32'h0000_0020, 0, 0);
        check("ram_rdw_new", read_data, 32'h2222_2222);

        drive(0, 0, A_FIFO, 0, 0);
        check("fifo_rd_zero", read_data, 32'h0);
        drive(0, 1, A_RSVD, 32'h1234_5678, 0);
        check("rsvd_rd", read_data, 32'h0);

        // Fill to overflow
        for (int unsigned i = 1; i <= 5; i++) begin
            drive(0, 1, A_FIFO, i, 0);
        end
        drive(0, 0, A_STATUS, 0, 0);
        check("ovf_status", read_data, 32'h34);
        check("ovf_odata", out_data, 32'h1);
        check("ovf_valid", {31'b0, out_valid}, 32'h1);
        drive(0, 1, A_STATUS, 32'hFFFF_FFFF, 0);
        drive(0, 0, A_STATUS, 0, 0);
        check("ovf_clear", read_data, 32'h14);

        // Push into full FIFO with simultaneous pop
        drive(0, 1, A_FIFO, 32'hA, 1);
        check("fullpp_head", out_data, 32'h1);
        drive(0, 0, A_STATUS, 0, 0);
        check("fullpp_status", read_data, 32'h14);
        for (int unsigned i = 0; i < 4; i++) begin
            drive(0, 0, A_STATUS, 0, 1);
            check($sformatf("pop%0d", i), out_data, pop_exp[i]);
        end
        drive(0, 0, A_STATUS, 0, 0);
        check("drain_valid", {31'b0, out_valid}, 32'h0);
        check("drain_odata", out_data, 32'h0);
        check("drain_status", read_data, 32'h08);

        // Simultaneous push/pop at count 1
        drive(0, 1, A_FIFO, 32'h7, 0);
        drive(0, 1, A_FIFO, 32'h8, 1);
        check("pp1_head_before", out_data, 32'h7);
        drive(0, 0, A_STATUS, 0, 0);
        check("pp1_status", read_data, 32'h01);
        check("pp1_head", out_data, 32'h8);

        // Cycle counter load and wrap
        drive(0, 1, A_CNT, 32'hFFFF_FFFE, 0);
`ifdef CYCLE_COUNTER_EN
        drive(0, 0, A_CNT, 0, 0);
        check("cnt0", read_data, 32'hFFFF_FFFE);
        drive(0, 0, A_CNT, 0, 0);
        check("cnt1", read_data, 32'hFFFF_FFFF);
        drive(0, 0, A_CNT, 0, 0);
        check("cnt2", read_data, 32'h0);
`else
        for (int unsigned i = 0; i < 3; i++) begin
            drive(0, 0, A_CNT, 0, 0);
            check($sformatf("cnt%0d", i), read_data, 32'h0);
        end
`endif

        // Reset suppresses writes and pops
        drive(0, 1, A_FIFO, 32'h55, 0);
        drive(1, 1, A_FIFO, 32'h66, 1);
        drive(0, 0, A_STATUS, 0, 0);
        check("rstw_valid", {31'b0, out_valid}, 32'h0);
        check("rstw_status", read_data, 32'h08);
        drive(1, 1, 32'h0000_0010, 32'h0, 0);
        drive(0, 0, 32'h0000_0010, 0, 0);
        check("rstw_ram", read_data, 32'hDEAD_BEEF);
        drive(1, 1, A_CNT, 32'h1234, 0);
        drive(0, 0, A_CNT, 0, 0);
        check("rstw_cnt", read_data, 32'h0);
        drive(1, 1, A_STATUS, 0, 0);
        drive(0, 0, A_STATUS, 0, 0);
        check("rstw_status2", read_data, 32'h08);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
